// File: rtl/retire_trace_unit_pkg.sv
// Shared types for the retirement trace unit: record layout, record kinds,
// unit state and the commit classifier.
package retire_trace_unit_pkg;

    localparam int DEFAULT_DEPTH      = 8;
    localparam int DEFAULT_MAX_CYCLES = 100000;

    typedef enum logic [2:0] {
        KIND_REG  = 3'd0,
        KIND_LD   = 3'd1,
        KIND_ST   = 3'd2,
        KIND_NOP  = 3'd3,
        KIND_HALT = 3'd4
    } trace_kind_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DONE    = 2'd1,
        ST_TIMEOUT = 2'd2
    } unit_state_t;

    typedef struct packed {
        trace_kind_t kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [15:0] inst;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] addr;
    } trace_rec_t;

    // A load is a register write with memory enabled; register writes
    // outrank a halt, and a halt outranks a store.
    function automatic trace_kind_t classifyCommit(
        input logic regWrite,
        input logic memRead,
        input logic memWrite,
        input logic halt
    );
        trace_kind_t k;
        if (regWrite && memRead)
            k = KIND_LD;
        else if (regWrite)
            k = KIND_REG;
        else if (halt)
            k = KIND_HALT;
        else if (memWrite)
            k = KIND_ST;
        else
            k = KIND_NOP;
        return k;
    endfunction

endpackage

// File: rtl/retire_trace_unit_fifo.sv
// Trace record FIFO: one push and one pop per cycle, push accepted into a
// full FIFO when a pop happens in the same cycle.
module trace_fifo
    import retire_trace_unit_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  trace_rec_t pushRec,
    input  logic       pop,
    output trace_rec_t headRec,
    output logic       full,
    output logic       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    trace_rec_t       mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign headRec = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush)
                wrPtr <= wrPtr + 1'b1;
            if (doPop)
                rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (doPush)
            mem[wrPtr] <= pushRec;
    end

endmodule

// File: rtl/retire_trace_unit.sv
// Retirement monitor: classifies each commit cycle into a numbered trace record
// and buffers it for a valid/ready consumer. Build option RETIRE_TRACE_NOP_EN.
module retire_trace_unit
    import retire_trace_unit_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic [15:0] inst,
    input  logic        reg_write,
    input  logic [3:0]  dst_reg,
    input  logic [15:0] dst_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        hlt,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [2:0]  trc_kind,
    output logic [31:0] trc_inum,
    output logic [15:0] trc_pc,
    output logic [15:0] trc_inst,
    output logic [15:0] trc_a,
    output logic [15:0] trc_b,
    output logic [15:0] trc_addr,
    output logic [31:0] cycle_count,
    output logic [31:0] inst_count,
    output logic [7:0]  drop_count,
    output logic        halted,
    output logic        timeout,
    output logic        overflow
);
    unit_state_t state;
    unit_state_t stateNext;
    trace_kind_t kind;
    trace_rec_t  rec;
    trace_rec_t  headRec;
    trace_rec_t  fifoIn;
    trace_rec_t  outRec;
    trace_rec_t  pendRec;
    logic        sampling;
    logic        isHalt;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        fifoPush;
    logic        popFire;
    logic        roomNow;
    logic        wantPush;
    logic        dropNow;
    logic        holdHalt;
    logic        pendValid;
    logic [31:0] cycleNext;

    assign kind      = classifyCommit(reg_write, mem_read, mem_write, hlt);
    assign cycleNext = cycle_count + 32'd1;

    always_comb begin
        rec      = '0;
        rec.kind = kind;
        rec.inum = inst_count;
        rec.pc   = pc;
        rec.inst = inst;
        case (kind)
            KIND_REG: begin
                rec.a = {12'h000, dst_reg};
                rec.b = dst_data;
            end
            KIND_LD: begin
                rec.a    = {12'h000, dst_reg};
                rec.b    = dst_data;
                rec.addr = mem_addr;
            end
            KIND_ST: begin
                rec.a = mem_addr;
                rec.b = mem_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_RUN;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_RUN: begin
                if (kind == KIND_HALT)
                    stateNext = ST_DONE;
                else if (cycleNext == 32'(MAX_CYCLES))
                    stateNext = ST_TIMEOUT;
            end
            default: stateNext = state;
        endcase
    end

    always_comb begin
        sampling = (state == ST_RUN);
        isHalt   = sampling && (kind == KIND_HALT);
    end

    assign popFire = !fifoEmpty && trc_ready;
    assign roomNow = !fifoFull || popFire;

`ifdef RETIRE_TRACE_NOP_EN
    assign wantPush = sampling;
`else
    assign wantPush = sampling && (kind != KIND_NOP);
`endif

    // A halt that finds no room parks in the pending slot instead of dropping;
    // once parked it owns the FIFO input because sampling has stopped.
    assign dropNow  = wantPush && !isHalt && !roomNow;
    assign holdHalt = isHalt && !roomNow;
    assign fifoPush = pendValid ? !fifoFull : (wantPush && roomNow);
    assign fifoIn   = pendValid ? pendRec : rec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
            pendValid   <= 1'b0;
        end else begin
            if (sampling) begin
                cycle_count <= cycleNext;
                inst_count  <= inst_count + 32'd1;
            end
            if (isHalt)
                halted <= 1'b1;
            if (sampling && (stateNext == ST_TIMEOUT))
                timeout <= 1'b1;
            if (dropNow) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
            end
            if (holdHalt)
                pendValid <= 1'b1;
            else if (pendValid && !fifoFull)
                pendValid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (holdHalt)
            pendRec <= rec;
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifoPush),
        .pushRec (fifoIn),
        .pop     (popFire),
        .headRec (headRec),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    // Fields read as zero whenever no record is offered.
    assign outRec    = fifoEmpty ? '0 : headRec;
    assign trc_valid = !fifoEmpty;
    assign trc_kind  = outRec.kind;
    assign trc_inum  = outRec.inum;
    assign trc_pc    = outRec.pc;
    assign trc_inst  = outRec.inst;
    assign trc_a     = outRec.a;
    assign trc_b     = outRec.b;
    assign trc_addr  = outRec.addr;

endmodule
